// File: rtl/flap_pkg.sv
// Shared types and default sizing for the bird motion controller.
package flap_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } flap_state_t;

    localparam int GRAV_PERIOD_DEF = 50;
    localparam int ROWS_DEF        = 8;
    localparam int START_ROW_DEF   = 3;

endpackage

// File: rtl/flap_ctrl_key_pulse.sv
// Key conditioner: brings an asynchronous key into the clock domain and
// emits a single-cycle pulse on each rising edge. Holding the key yields
// exactly one pulse.
module key_pulse (
    input  logic clk,
    input  logic reset,
    input  logic i_key,
    output logic o_pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    // Two-flop synchronizer followed by a previous-value flop for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Combinational edge so the caller can register it on the very next edge
    assign o_pulse = r_sync2 & ~r_prev;

endmodule

// File: rtl/flap_ctrl.sv
// Bird motion controller: turns flap key edges and a gravity timer into
// mutually exclusive one-cycle press/gravity pulses, tracks the bird row so
// it never leaves the column, and latches game-over on floor crash or hit.
module flap_ctrl
    import flap_pkg::*;
#(
    parameter int GRAV_PERIOD = GRAV_PERIOD_DEF,
    parameter int ROWS        = ROWS_DEF,
    parameter int START_ROW   = START_ROW_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    key_in,
    input  logic                    hit,
    output logic                    press,
    output logic                    gravity,
    output logic [$clog2(ROWS)-1:0] row,
    output logic                    at_top,
    output logic                    at_bottom,
    output logic                    crash
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(GRAV_PERIOD);

    localparam logic [RW-1:0] TOP_ROW  = RW'(ROWS - 1);
    localparam logic [RW-1:0] INIT_ROW = RW'(START_ROW);
    localparam logic [CW-1:0] RELOAD   = CW'(GRAV_PERIOD - 1);

    flap_state_t   r_state;
    flap_state_t   w_state_nxt;
    logic [RW-1:0] r_row;
    logic [RW-1:0] w_row_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_press;
    logic          w_press_nxt;
    logic          r_grav;
    logic          w_grav_nxt;
    logic          r_crash;
    logic          w_key_pulse;
    logic          w_key_evt;
    logic          w_at_top;
    logic          w_at_bottom;

    key_pulse u_key_pulse (
        .clk     (clk),
        .reset   (reset),
        .i_key   (key_in),
        .o_pulse (w_key_pulse)
    );

    // Edges seen while frozen are dropped, never queued
    assign w_key_evt   = w_key_pulse & enable;
    assign w_at_top    = (r_row == TOP_ROW);
    assign w_at_bottom = (r_row == {RW{1'b0}});

    // Next-state, row, timer and pulse decisions; hit beats flap beats gravity
    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_cnt_nxt   = r_cnt;
        w_press_nxt = 1'b0;
        w_grav_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = RELOAD;
                if (w_key_evt) begin
                    // The starting key is consumed and does not flap
                    w_state_nxt = PLAY;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            PLAY: begin
                if (!enable) begin
                    w_state_nxt = PLAY;
                end else if (hit) begin
                    w_state_nxt = OVER;
                end else if (w_key_evt && !w_at_top) begin
                    // A flap restarts the fall delay
                    w_press_nxt = 1'b1;
                    w_row_nxt   = r_row + RW'(1);
                    w_cnt_nxt   = RELOAD;
                end else if (r_cnt == {CW{1'b0}}) begin
                    if (w_at_bottom) begin
                        w_state_nxt = OVER;
                    end else begin
                        w_grav_nxt = 1'b1;
                        w_row_nxt  = r_row - RW'(1);
                        w_cnt_nxt  = RELOAD;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            OVER: begin
                w_state_nxt = OVER;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, row, timer and registered pulse outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_row   <= INIT_ROW;
            r_cnt   <= RELOAD;
            r_press <= 1'b0;
            r_grav  <= 1'b0;
            r_crash <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_cnt   <= w_cnt_nxt;
            r_press <= w_press_nxt;
            r_grav  <= w_grav_nxt;
            r_crash <= (w_state_nxt == OVER);
        end
    end

    assign press     = r_press;
    assign gravity   = r_grav;
    assign row       = r_row;
    assign crash     = r_crash;
    assign at_top    = w_at_top;
    assign at_bottom = w_at_bottom;

endmodule

// File: tb/tb_flap_ctrl.sv
// Scoreboard bench for flap_ctrl: a cycle-level reference model predicts each
// pulse (cycle, kind, resulting row) into a queue; a negedge monitor pops and
// compares whenever the DUT presents a pulse, and checks row/crash/flags.
module tb_flap_ctrl;

    localparam int GP        = 4;
    localparam int ROWS      = 8;
    localparam int START_ROW = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       key_in;
    logic       hit;
    logic       press;
    logic       gravity;
    logic [2:0] row;
    logic       at_top;
    logic       at_bottom;
    logic       crash;

    always #5 clk = ~clk;

    flap_ctrl #(.GRAV_PERIOD(GP), .ROWS(ROWS), .START_ROW(START_ROW)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .key_in    (key_in),
        .hit       (hit),
        .press     (press),
        .gravity   (gravity),
        .row       (row),
        .at_top    (at_top),
        .at_bottom (at_bottom),
        .crash     (crash)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int cyc;
        bit is_press;
        int row;
    } exp_t;
    exp_t q[$];

    // Reference model state: mode 0 = waiting, 1 = flying, 2 = game over
    int     m_mode;
    int     m_row;
    int     m_since;
    bit     m_hist[$];
    bit     m_ev;
    exp_t   m_e;
    exp_t   got;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: key history sampled each edge; a flap is a key seen
    // high two samples ago that was low three samples ago, while enabled.
    initial begin
        m_mode = 0; m_row = START_ROW; m_since = 0;
        m_hist = '{1'b0, 1'b0, 1'b0};
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_mode = 0; m_row = START_ROW; m_since = 0;
                m_hist = '{1'b0, 1'b0, 1'b0};
                q.delete();
            end else begin
                cyc++;
                m_ev = m_hist[1] && !m_hist[2] && enable;
                if (m_mode == 0) begin
                    if (m_ev) begin
                        m_mode = 1;
                        m_since = 0;
                    end
                end else if (m_mode == 1 && enable) begin
                    if (hit) begin
                        m_mode = 2;
                    end else if (m_ev && m_row < ROWS - 1) begin
                        m_row = m_row + 1;
                        m_since = 0;
                        m_e = '{cyc, 1'b1, m_row};
                        q.push_back(m_e);
                    end else if (m_since == GP - 1) begin
                        if (m_row == 0) begin
                            m_mode = 2;
                        end else begin
                            m_row = m_row - 1;
                            m_since = 0;
                            m_e = '{cyc, 1'b0, m_row};
                            q.push_back(m_e);
                        end
                    end else begin
                        m_since = m_since + 1;
                    end
                end
                m_hist.push_front(key_in);
                void'(m_hist.pop_back());
            end
        end
    end

    // Monitor: compare presented pulses against the scoreboard and check status
    initial begin
        forever begin
            @(negedge clk);
            chk("row", row, m_row);
            chk("crash", crash, m_mode == 2);
            chk("at_top", at_top, m_row == ROWS - 1);
            chk("at_bottom", at_bottom, m_row == 0);
            chk("press_and_gravity", press & gravity, 1'b0);
            if (press || gravity) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: press=%0d gravity=%0d at cycle %0d, none required",
                             press, gravity, cyc);
                end else begin
                    got = q.pop_front();
                    chk("pulse_cycle", cyc, got.cyc);
                    chk("pulse_kind_press", press, got.is_press);
                    chk("pulse_row", row, got.row);
                end
            end else if (q.size() > 0) begin
                got = q.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL missing_pulse: no pulse at cycle %0d, required press=%0d row=%0d",
                         cyc, got.is_press, got.row);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic flap();
        key_in = 1'b1;
        tick(1);
        key_in = 1'b0;
        tick(1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; key_in = 1'b0; hit = 1'b0;
        #1;
        chk("reset_row", row, 3);
        chk("reset_press", press, 1'b0);
        chk("reset_gravity", gravity, 1'b0);
        chk("reset_crash", crash, 1'b0);
        tick(2);
        reset = 1'b0;

        // Held key starts the game without a flap, then fall to the floor
        key_in = 1'b1;
        tick(20);
        key_in = 1'b0;
        tick(GP * 5 + 4);
        chk("floor_crash", crash, 1'b1);
        chk("floor_row", row, 0);

        // Reach row 5, then reset asynchronously mid-cycle while press is high
        do_reset();
        flap();
        flap();
        flap();
        tick(1);
        chk("row_before_reset", row, 5);
        reset = 1'b1;
        #1;
        chk("async_reset_press", press, 1'b0);
        chk("async_reset_row", row, 3);
        chk("async_reset_crash", crash, 1'b0);
        #1;
        reset = 1'b0;
        tick(10);

        // Single flap from row 3, then gravity timing after the press
        flap();
        tick(1);
        flap();
        tick(10);

        // Climb to the top; extra flaps are swallowed
        do_reset();
        flap();
        repeat (7) flap();
        tick(8);

        // Flaps at varied spacing so one lands on the gravity expiry
        for (int d = 0; d < 6; d++) begin
            flap();
            tick(d);
        end
        tick(6);

        // Hit coincident with a key event at row 4
        do_reset();
        flap();
        flap();
        tick(1);
        key_in = 1'b1;
        tick(2);
        hit = 1'b1;
        tick(1);
        hit = 1'b0;
        key_in = 1'b0;
        tick(3);
        chk("hit_crash", crash, 1'b1);
        repeat (4) flap();
        tick(10);
        chk("hit_crash_sticky", crash, 1'b1);

        // Randomized play with enable gaps, hits and occasional resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 2) == 0) key_in = ~key_in;
            hit = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 149) == 0) begin
                hit = 1'b0;
                do_reset();
            end else begin
                tick(1);
            end
        end
        enable = 1'b1; hit = 1'b0; key_in = 1'b0;
        tick(3);
        chk("scoreboard_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/flap_ctrl.md
Name: flap_ctrl

Overview:
Motion controller that drives the bird-light column: produces the single-cycle press (flap up) and gravity (fall one row) pulses that every bird light consumes.
- Tracks the bird's row so it never emits a move that would push the bird off the column.
- Guarantees press and gravity are never high in the same cycle.
- Detects floor crashes and external obstacle hits, and holds the game-over condition.

Parameters:
GRAV_PERIOD, 50, clock cycles between gravity pulses while playing (>=2)
ROWS, 8, number of lights in the column
START_ROW, 3, row loaded on reset (0 = bottom, ROWS-1 = top)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  1 = run; 0 = freeze the counter, emit no pulses, drop key edges
key_in  input  1  raw flap key, active-high, asynchronous to clk
hit  input  1  obstacle collision from the pipe logic, synchronous to clk
press  output  1  one-cycle flap pulse to the bird lights
gravity  output  1  one-cycle fall pulse to the bird lights
row  output  $clog2(ROWS)  current bird row
at_top  output  1  row == ROWS-1
at_bottom  output  1  row == 0
crash  output  1  high in OVER state

Behaviour:
- Reset is asynchronous and active-high. It forces:
  - state = IDLE, row = START_ROW
  - gravity counter = GRAV_PERIOD-1
  - sync/edge flops = 0
  - press = gravity = crash = 0
- Key path: 2-flop synchronizer, then a previous-value flop.
  - A key event is sync2 & ~prev & enable.
  - If key_in rises before clock edge k, press is high only in the cycle after edge k+2, for exactly one cycle.
  - Holding the key yields one event. Key edges while enable = 0 are discarded, not queued.
- States:
  - IDLE: no pulses; counter held at GRAV_PERIOD-1. A key event moves to PLAY. That key event is consumed and produces no press.
  - PLAY:
    - Counter decrements each enabled cycle.
    - When the counter is 0 and no key event is present, register gravity = 1 and reload the counter.
    - A key event registers press = 1 and reloads the counter to GRAV_PERIOD-1. This restarts the fall delay after every flap.
    - Key event and counter 0 in the same cycle: press wins, gravity is suppressed, counter reloads.
    - At the top (row == ROWS-1), a key event is swallowed: no press, counter not reloaded.
    - At the bottom (row == 0), a gravity expiry emits no pulse and moves to OVER.
    - hit = 1 moves to OVER next cycle. hit takes priority over a same-cycle key event or gravity, which are then dropped.
  - OVER: crash = 1, no pulses, row frozen. The state is sticky until reset.
- Row update: row changes on the same edge that registers the pulse (+1 for press, -1 for gravity). row is therefore always consistent with the pulse being presented.
- Invariants:
  - press & gravity is never 1.
  - row never wraps.
  - No pulses outside PLAY.
- enable = 0 in PLAY: counter, row and state are frozen. Outputs register as 0 for the next cycle.
- at_top and at_bottom are combinational from row.

Decomposition:
- Package flap_pkg:
  - typedef enum flap_state_t {IDLE, PLAY, OVER}
  - default constants for GRAV_PERIOD, ROWS and START_ROW
- Sub-module key_pulse (synchronizer + rising-edge detect, one-cycle output). It is reused later for the restart key.

Test Plan:
Bench parameters: GRAV_PERIOD=4, ROWS=8, START_ROW=3.
1. Reset mid-PLAY at row 5 -> outputs immediately 0 without waiting for clk, row=3, state IDLE; no pulses for 10 cycles with key low.
2. IDLE, key_in 0->1 held 20 cycles -> state PLAY, no press ever. Gravity then pulses every 4 cycles: row 3->2->1->0. The next expiry gives crash=1 and no gravity pulse.
3. PLAY at row 3, key rises once -> press exactly one cycle, 3 edges after the rise; row=4; next gravity exactly 4 cycles after the press.
4. Key event aligned with counter 0 -> press=1, gravity=0 that cycle; row +1; gravity resumes 4 cycles later.
5. Row 7, key event -> no press, row stays 7; following gravity -> row 6.
6. hit=1 coincident with a key event at row 4 -> no press, crash=1 next cycle and stays high; further key and gravity activity produces no pulses until reset.
